// File: rtl/eceg_decrypt_pkg.sv
// Shared field parameters and mod-P helpers for the EC-ElGamal decryptor.
// Curve y^2 = x^3 + A*x + b over GF(P). Only A and P enter the add/double formulas.
package eceg_decrypt_pkg;

  localparam int DATAWIDTH = 5;
  localparam logic [DATAWIDTH-1:0] P = DATAWIDTH'(17);
  localparam logic [DATAWIDTH-1:0] A = DATAWIDTH'(2);
  localparam int CW = (DATAWIDTH > 1) ? $clog2(DATAWIDTH) : 1;

  typedef logic [DATAWIDTH-1:0] fe_t;

  typedef enum logic [1:0] {
    PA_IDLE,
    PA_INV,
    PA_FIN,
    PA_RDY
  } pa_state_e;

  function automatic fe_t mod_add(input fe_t a, input fe_t b);
    logic [DATAWIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, P}) s = s - {1'b0, P};
    return s[DATAWIDTH-1:0];
  endfunction

  function automatic fe_t mod_sub(input fe_t a, input fe_t b);
    logic [DATAWIDTH:0] s;
    s = {1'b0, a} + {1'b0, P} - {1'b0, b};
    if (s >= {1'b0, P}) s = s - {1'b0, P};
    return s[DATAWIDTH-1:0];
  endfunction

  function automatic fe_t mod_mul(input fe_t a, input fe_t b);
    logic [2*DATAWIDTH-1:0] prod;
    prod = {{DATAWIDTH{1'b0}}, a} * {{DATAWIDTH{1'b0}}, b};
    prod = prod % {{DATAWIDTH{1'b0}}, P};
    return prod[DATAWIDTH-1:0];
  endfunction

endpackage

// File: rtl/ec_point_add.sv
// Affine point add/double over GF(P) with Fermat inversion (den^(P-2)).
// Handshake: go_i is a one-cycle request accepted only in PA_IDLE; ready_o pulses one cycle when r_* is valid.
module ec_point_add
  import eceg_decrypt_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 go_i,
  input  logic                 dbl_i,
  input  logic [DATAWIDTH-1:0] p1_x_i,
  input  logic [DATAWIDTH-1:0] p1_y_i,
  input  logic [DATAWIDTH-1:0] p2_x_i,
  input  logic [DATAWIDTH-1:0] p2_y_i,
  output logic                 ready_o,
  output logic [DATAWIDTH-1:0] r_x_o,
  output logic [DATAWIDTH-1:0] r_y_o,
  output logic                 r_inf_o
);

  localparam fe_t EXP = P - DATAWIDTH'(2);

  pa_state_e st_q, st_d;
  fe_t x1_q, x1_d, y1_q, y1_d, x2_q, x2_d;
  fe_t num_q, num_d, den_q, den_d, acc_q, acc_d;
  fe_t rx_q, rx_d, ry_q, ry_d;
  logic rinf_q, rinf_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic same_pt, do_dbl, is_inf;
  fe_t x_sq, acc_sq, lam, x3, y3;

  // Adding a point to itself is a doubling; equal x otherwise means Q = -P.
  assign same_pt = (p1_x_i == p2_x_i) && (p1_y_i == p2_y_i);
  assign do_dbl  = dbl_i || same_pt;
  assign is_inf  = do_dbl ? (p1_y_i == '0) : (p1_x_i == p2_x_i);
  assign x_sq    = mod_mul(p1_x_i, p1_x_i);
  assign acc_sq  = mod_mul(acc_q, acc_q);
  assign lam     = mod_mul(num_q, acc_q);
  assign x3      = mod_sub(mod_sub(mod_mul(lam, lam), x1_q), x2_q);
  assign y3      = mod_sub(mod_mul(lam, mod_sub(x1_q, x3)), y1_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= PA_IDLE;
      x1_q   <= '0;
      y1_q   <= '0;
      x2_q   <= '0;
      num_q  <= '0;
      den_q  <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      rx_q   <= '0;
      ry_q   <= '0;
      rinf_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      x1_q   <= x1_d;
      y1_q   <= y1_d;
      x2_q   <= x2_d;
      num_q  <= num_d;
      den_q  <= den_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      rx_q   <= rx_d;
      ry_q   <= ry_d;
      rinf_q <= rinf_d;
    end
  end

  always_comb begin
    st_d   = st_q;
    x1_d   = x1_q;
    y1_d   = y1_q;
    x2_d   = x2_q;
    num_d  = num_q;
    den_d  = den_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    rx_d   = rx_q;
    ry_d   = ry_q;
    rinf_d = rinf_q;
    case (st_q)
      PA_IDLE: begin
        if (go_i) begin
          x1_d = p1_x_i;
          y1_d = p1_y_i;
          x2_d = do_dbl ? p1_x_i : p2_x_i;
          if (is_inf) begin
            rx_d   = '0;
            ry_d   = '0;
            rinf_d = 1'b1;
            st_d   = PA_RDY;
          end else begin
            num_d = do_dbl ? mod_add(mod_add(x_sq, x_sq), mod_add(x_sq, A))
                           : mod_sub(p2_y_i, p1_y_i);
            den_d = do_dbl ? mod_add(p1_y_i, p1_y_i) : mod_sub(p2_x_i, p1_x_i);
            acc_d = DATAWIDTH'(1);
            cnt_d = CW'(DATAWIDTH - 1);
            st_d  = PA_INV;
          end
        end
      end
      PA_INV: begin
        acc_d = EXP[cnt_q] ? mod_mul(acc_sq, den_q) : acc_sq;
        if (cnt_q == '0) st_d = PA_FIN;
        else cnt_d = cnt_q - 1'b1;
      end
      PA_FIN: begin
        rx_d   = x3;
        ry_d   = y3;
        rinf_d = 1'b0;
        st_d   = PA_RDY;
      end
      PA_RDY:  st_d = PA_IDLE;
      default: st_d = PA_IDLE;
    endcase
  end

  always_comb begin
    ready_o = (st_q == PA_RDY);
    r_x_o   = rx_q;
    r_y_o   = ry_q;
    r_inf_o = rinf_q;
  end

endmodule

// File: rtl/eceg_decrypt.sv
// EC-ElGamal decryption M = C2 - d*C1 using left-to-right double-and-add.
// Handshake: start is sampled only in IDLE; done pulses one cycle with m_* valid; m_* hold until the next done.
module eceg_decrypt #(
  parameter int DATAWIDTH = eceg_decrypt_pkg::DATAWIDTH,
  parameter int KEYWIDTH  = DATAWIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [DATAWIDTH-1:0] c1_x,
  input  logic [DATAWIDTH-1:0] c1_y,
  input  logic [DATAWIDTH-1:0] c2_x,
  input  logic [DATAWIDTH-1:0] c2_y,
  input  logic [KEYWIDTH-1:0]  priv_key,
  output logic                 busy,
  output logic                 done,
  output logic [DATAWIDTH-1:0] m_x,
  output logic [DATAWIDTH-1:0] m_y,
  output logic                 m_inf,
  output logic [2:0]           dbg_state_o
);
  import eceg_decrypt_pkg::*;

  localparam int IW = (KEYWIDTH > 1) ? $clog2(KEYWIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE, LOAD, DOUBLE, ADD, NEGATE, FINAL, DONE
  } state_e;

  state_e state_q, state_d;
  logic [DATAWIDTH-1:0] c1x_q, c1x_d, c1y_q, c1y_d, c2x_q, c2x_d, c2y_q, c2y_d;
  logic [DATAWIDTH-1:0] sx_q, sx_d, sy_q, sy_d, mx_q, mx_d, my_q, my_d;
  logic [KEYWIDTH-1:0]  key_q, key_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic sinf_q, sinf_d, minf_q, minf_d, pend_q, pend_d;

  logic pa_go, pa_dbl, pa_ready, pa_rinf, op_done;
  logic [DATAWIDTH-1:0] pa_bx, pa_by, pa_rx, pa_ry;

  assign op_done = pend_q && pa_ready;

  ec_point_add u_pa (
    .clk     (clk),
    .rst_n   (rst_n),
    .go_i    (pa_go),
    .dbl_i   (pa_dbl),
    .p1_x_i  (sx_q),
    .p1_y_i  (sy_q),
    .p2_x_i  (pa_bx),
    .p2_y_i  (pa_by),
    .ready_o (pa_ready),
    .r_x_o   (pa_rx),
    .r_y_o   (pa_ry),
    .r_inf_o (pa_rinf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      c1x_q   <= '0;
      c1y_q   <= '0;
      c2x_q   <= '0;
      c2y_q   <= '0;
      key_q   <= '0;
      sx_q    <= '0;
      sy_q    <= '0;
      sinf_q  <= 1'b0;
      idx_q   <= '0;
      pend_q  <= 1'b0;
      mx_q    <= '0;
      my_q    <= '0;
      minf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      c1x_q   <= c1x_d;
      c1y_q   <= c1y_d;
      c2x_q   <= c2x_d;
      c2y_q   <= c2y_d;
      key_q   <= key_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      sinf_q  <= sinf_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      mx_q    <= mx_d;
      my_q    <= my_d;
      minf_q  <= minf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    c1x_d   = c1x_q;
    c1y_d   = c1y_q;
    c2x_d   = c2x_q;
    c2y_d   = c2y_q;
    key_d   = key_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    sinf_d  = sinf_q;
    idx_d   = idx_q;
    pend_d  = pend_q;
    mx_d    = mx_q;
    my_d    = my_q;
    minf_d  = minf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          c1x_d   = c1_x;
          c1y_d   = c1_y;
          c2x_d   = c2_x;
          c2y_d   = c2_y;
          key_d   = priv_key;
          state_d = LOAD;
        end
      end
      LOAD: begin
        sx_d    = '0;
        sy_d    = '0;
        sinf_d  = 1'b1;
        idx_d   = IW'(KEYWIDTH - 1);
        pend_d  = 1'b0;
        state_d = DOUBLE;
      end
      // An infinite accumulator resolves locally in one cycle; otherwise issue go once and wait.
      DOUBLE: begin
        if (sinf_q || op_done) begin
          if (!sinf_q) begin
            sx_d   = pa_rx;
            sy_d   = pa_ry;
            sinf_d = pa_rinf;
            pend_d = 1'b0;
          end
          if (key_q[idx_q]) state_d = ADD;
          else if (idx_q == '0) state_d = NEGATE;
          else begin
            idx_d   = idx_q - 1'b1;
            state_d = DOUBLE;
          end
        end else if (!pend_q) begin
          pend_d = 1'b1;
        end
      end
      ADD: begin
        if (sinf_q || op_done) begin
          if (sinf_q) begin
            sx_d   = c1x_q;
            sy_d   = c1y_q;
            sinf_d = 1'b0;
          end else begin
            sx_d   = pa_rx;
            sy_d   = pa_ry;
            sinf_d = pa_rinf;
            pend_d = 1'b0;
          end
          if (idx_q == '0) state_d = NEGATE;
          else begin
            idx_d   = idx_q - 1'b1;
            state_d = DOUBLE;
          end
        end else if (!pend_q) begin
          pend_d = 1'b1;
        end
      end
      NEGATE: begin
        if (!sinf_q && (sy_q != '0)) sy_d = P - sy_q;
        state_d = FINAL;
      end
      FINAL: begin
        if (sinf_q) begin
          mx_d    = c2x_q;
          my_d    = c2y_q;
          minf_d  = 1'b0;
          state_d = DONE;
        end else if (op_done) begin
          mx_d    = pa_rx;
          my_d    = pa_ry;
          minf_d  = pa_rinf;
          pend_d  = 1'b0;
          state_d = DONE;
        end else if (!pend_q) begin
          pend_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q != IDLE);
    done        = (state_q == DONE);
    m_x         = mx_q;
    m_y         = my_q;
    m_inf       = minf_q;
    dbg_state_o = state_q;
    pa_go       = ((state_q == DOUBLE) || (state_q == ADD) || (state_q == FINAL))
                  && !pend_q && !sinf_q;
    pa_dbl      = (state_q == DOUBLE);
    pa_bx       = (state_q == FINAL) ? c2x_q : c1x_q;
    pa_by       = (state_q == FINAL) ? c2y_q : c1y_q;
  end

endmodule

// File: tb/tb_eceg_decrypt.sv
// Directed bench for eceg_decrypt on y^2 = x^3 + 2x + 2 mod 17, G = (5,1), order 19.
// Expected plaintexts are queued at issue time and popped by a monitor on each done pulse.
module tb_eceg_decrypt;

  localparam int DW = 5;
  localparam int KW = 5;
  localparam int EW = 2 * DW + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [DW-1:0] c1_x, c1_y, c2_x, c2_y;
  logic [KW-1:0] priv_key;
  logic          busy, done, m_inf;
  logic [DW-1:0] m_x, m_y;
  logic [2:0]    dbg_state;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;
  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  eceg_decrypt #(.DATAWIDTH(DW), .KEYWIDTH(KW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .c1_x        (c1_x),
    .c1_y        (c1_y),
    .c2_x        (c2_x),
    .c2_y        (c2_y),
    .priv_key    (priv_key),
    .busy        (busy),
    .done        (done),
    .m_x         (m_x),
    .m_y         (m_y),
    .m_inf       (m_inf),
    .dbg_state_o (dbg_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Caller is positioned at a negedge; start is seen by the following posedge.
  task automatic issue(input int ax, input int ay, input int bx, input int by, input int d,
                       input bit push, input int ex, input int ey, input int einf);
    logic [EW-1:0] e;
    c1_x     = DW'(ax);
    c1_y     = DW'(ay);
    c2_x     = DW'(bx);
    c2_y     = DW'(by);
    priv_key = KW'(d);
    start    = 1'b1;
    if (push) begin
      e = {1'(einf), DW'(ex), DW'(ey)};
      exp_q.push_back(e);
    end
    @(negedge clk);
    start    = 1'b0;
    c1_x     = DW'($urandom_range(0, 31));
    c1_y     = DW'($urandom_range(0, 31));
    c2_x     = DW'($urandom_range(0, 31));
    c2_y     = DW'($urandom_range(0, 31));
    priv_key = KW'($urandom_range(0, 31));
  endtask

  task automatic wait_done(input int target, input string name);
    int n = 0;
    while (done_cnt < target && n < 3000) begin
      @(posedge clk);
      n++;
    end
    check(name, done_cnt, target);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done with empty queue, expected no done");
      end else begin
        mon_e = exp_q.pop_front();
        check("m_inf", m_inf, mon_e[2*DW]);
        check("m_x", m_x, mon_e[2*DW-1:DW]);
        check("m_y", m_y, mon_e[DW-1:0]);
      end
    end
  end

  initial begin
    int n;
    rst_n = 1'b0;
    start = 1'b0;
    c1_x = '0; c1_y = '0; c2_x = '0; c2_y = '0; priv_key = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_m_x", m_x, 0);
    check("rst_m_y", m_y, 0);
    check("rst_m_inf", m_inf, 0);
    check("rst_state", dbg_state, 0);

    // d=1, C2=2G -> G; start is live on the first edge after reset release
    rst_n = 1'b1;
    issue(5, 1, 6, 3, 1, 1, 5, 1, 0);
    check("busy_after_start", busy, 1);
    wait_done(1, "t1_done");

    // d=2, C2=5G -> 3G
    @(negedge clk);
    issue(5, 1, 9, 16, 2, 1, 10, 6, 0);
    wait_done(2, "t2_done");

    // d=0 -> M = C2
    @(negedge clk);
    issue(5, 1, 6, 3, 0, 1, 6, 3, 0);
    wait_done(3, "t3_done");

    // d=4, C2=4G -> infinity
    @(negedge clk);
    issue(5, 1, 3, 1, 4, 1, 0, 0, 1);
    wait_done(4, "t4_done");

    // start while busy is ignored
    @(negedge clk);
    issue(5, 1, 6, 3, 1, 1, 5, 1, 0);
    repeat (3) @(negedge clk);
    c2_x = DW'(9); c2_y = DW'(16); priv_key = KW'(2); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(5, "t5_done");
    repeat (40) @(negedge clk);
    check("single_done", done_cnt, 5);
    check("idle_after_done", busy, 0);
    check("hold_m_x", m_x, 5);
    check("hold_m_y", m_y, 1);

    // reset during DOUBLE aborts the run
    issue(5, 1, 0, 6, 7, 0, 0, 0, 0);
    n = 0;
    while (dbg_state !== 3'd2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("reach_double", dbg_state, 2);
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_m_x", m_x, 0);
    check("abort_m_y", m_y, 0);
    check("abort_m_inf", m_inf, 0);
    repeat (3) @(negedge clk);
    check("no_done_after_abort", done_cnt, 5);
    rst_n = 1'b1;
    issue(5, 1, 13, 7, 7, 1, 5, 1, 0);
    wait_done(6, "t6_done");

    // back-to-back: next start in the cycle right after done
    @(negedge clk);
    issue(5, 1, 9, 16, 2, 1, 10, 6, 0);
    wait_done(7, "t7a_done");
    @(negedge clk);
    issue(5, 1, 6, 3, 1, 1, 5, 1, 0);
    check("b2b_accepted", busy, 1);
    check("b2b_hold_m_x", m_x, 10);
    check("b2b_hold_m_y", m_y, 6);
    wait_done(8, "t7b_done");

    repeat (5) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    check("total_done", done_cnt, 8);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
